// File: rtl/digit_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_controller_if
// Brief    : Load handshake and display-pin bundle for digit_scan_controller.
// Revision : 1.0 - initial release
// ============================================================================
interface digit_scan_controller_if #(
    parameter int DIGITS = 2
);
    logic                  Enable;
    logic                  Load_Req;
    logic [4*DIGITS-1:0]   Load_Data;
    logic [DIGITS-1:0]     Load_Dp;
    logic                  Load_Ack;
    logic [DIGITS-1:0]     Col_Scan_Sig;
    logic [7:0]            Seg_Data;
    logic                  Frame_Done;

    modport master (
        output Enable, Load_Req, Load_Data, Load_Dp,
        input  Load_Ack, Col_Scan_Sig, Seg_Data, Frame_Done
    );

    modport slave (
        input  Enable, Load_Req, Load_Data, Load_Dp,
        output Load_Ack, Col_Scan_Sig, Seg_Data, Frame_Done
    );
endinterface
`default_nettype wire

// File: rtl/digit_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_controller
// Brief    : Multiplexed common-anode 7-segment scanner with blanking gaps and
//            frame-atomic shadow loading via a req/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module digit_scan_controller #(
    parameter int DIGITS       = 2,
    parameter int SCAN_CYCLES  = 500000,
    parameter int BLANK_CYCLES = 1000
) (
    input  wire                     CLK,
    input  wire                     RSTn,
    digit_scan_controller_if.slave  bus
);
    localparam int c_max_cycles = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
    localparam int c_idx_w      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_cnt_w-1:0] c_scan_last  = c_cnt_w'(SCAN_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_idx_w-1:0]    r_idx, w_idx_nxt;
    logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
    logic [4*DIGITS-1:0]   r_shadow_data;
    logic [DIGITS-1:0]     r_shadow_dp;
    logic                  r_ack;
    logic                  r_done;
    logic [DIGITS-1:0]     r_col;
    logic [7:0]            r_seg;

    logic                  w_frame_end;
    logic                  w_accept;
    logic [4*DIGITS-1:0]   w_data_src;
    logic [DIGITS-1:0]     w_dp_src;
    logic [3:0]            w_nib;
    logic                  w_dp;
    logic [DIGITS-1:0]     w_col;
    logic [7:0]            w_seg;

    function automatic logic [6:0] hexseg(input logic [3:0] nib);
        case (nib)
            4'h0: hexseg = 7'h3F;  4'h1: hexseg = 7'h06;
            4'h2: hexseg = 7'h5B;  4'h3: hexseg = 7'h4F;
            4'h4: hexseg = 7'h66;  4'h5: hexseg = 7'h6D;
            4'h6: hexseg = 7'h7D;  4'h7: hexseg = 7'h07;
            4'h8: hexseg = 7'h7F;  4'h9: hexseg = 7'h6F;
            4'hA: hexseg = 7'h77;  4'hB: hexseg = 7'h7C;
            4'hC: hexseg = 7'h39;  4'hD: hexseg = 7'h5E;
            4'hE: hexseg = 7'h79;  default: hexseg = 7'h71;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_frame_end = 1'b0;
        if (!bus.Enable) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SHOW;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
                SHOW: begin
                    if (r_cnt == c_scan_last) begin
                        w_state_nxt = BLANK;
                        w_cnt_nxt   = '0;
                    end
                end
                BLANK: begin
                    if (r_cnt == c_blank_last) begin
                        w_state_nxt = SHOW;
                        w_cnt_nxt   = '0;
                        if (r_idx == c_idx_last) begin
                            w_idx_nxt   = '0;
                            w_frame_end = 1'b1;
                        end else begin
                            w_idx_nxt   = r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Data accepted on this edge feeds the first digit of the new frame directly,
    // so the shadow and the displayed digit always change together.
    assign w_accept   = bus.Load_Req && !r_ack && ((r_state == IDLE) || w_frame_end);
    assign w_data_src = w_accept ? bus.Load_Data : r_shadow_data;
    assign w_dp_src   = w_accept ? bus.Load_Dp   : r_shadow_dp;

    always_comb begin
        w_nib = 4'h0;
        w_dp  = 1'b0;
        w_col = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_nxt == c_idx_w'(i)) begin
                w_nib = w_data_src[4*i +: 4];
                w_dp  = w_dp_src[i];
                w_col[i] = (w_state_nxt != SHOW);
            end
        end
        w_seg = (w_state_nxt == SHOW) ? ~{w_dp, hexseg(w_nib)} : 8'hFF;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_ack         <= 1'b0;
            r_done        <= 1'b0;
            r_col         <= '1;
            r_seg         <= 8'hFF;
        end else begin
            if (w_accept) begin
                r_shadow_data <= bus.Load_Data;
                r_shadow_dp   <= bus.Load_Dp;
            end
            r_ack  <= w_accept;
            r_done <= w_frame_end;
            r_col  <= w_col;
            r_seg  <= w_seg;
        end
    end

    assign bus.Load_Ack     = r_ack;
    assign bus.Frame_Done   = r_done;
    assign bus.Col_Scan_Sig = r_col;
    assign bus.Seg_Data     = r_seg;
endmodule
`default_nettype wire

// File: tb/tb_digit_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scan_controller
// Brief    : Directed vector bench for digit_scan_controller (2 digits, 4/2 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_scan_controller;
    logic CLK;
    logic RSTn;

    digit_scan_controller_if #(.DIGITS(2)) bus ();

    digit_scan_controller #(
        .DIGITS       (2),
        .SCAN_CYCLES  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rstn;
        logic       en;
        logic       req;
        logic [7:0] data;
        logic [1:0] dp;
        logic [1:0] col;
        logic [7:0] seg;
        logic       ack;
        logic       done;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input int n, input logic rstn, input logic en, input logic req,
                       input logic [7:0] data, input logic [1:0] dp, input logic [1:0] col,
                       input logic [7:0] seg, input logic ack, input logic done);
        vec_t v;
        v = '{rstn, en, req, data, dp, col, seg, ack, done};
        repeat (n) vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] col, input logic [7:0] seg,
                         input logic ack, input logic done);
        n_vec++;
        if (bus.Col_Scan_Sig !== col || bus.Seg_Data !== seg ||
            bus.Load_Ack !== ack || bus.Frame_Done !== done) begin
            n_bad++;
            $display("FAIL %s: got col=%b seg=%h ack=%b done=%b, want col=%b seg=%h ack=%b done=%b",
                     name, bus.Col_Scan_Sig, bus.Seg_Data, bus.Load_Ack, bus.Frame_Done,
                     col, seg, ack, done);
        end
    endtask

    task automatic step(input string name, input logic [1:0] col, input logic [7:0] seg,
                        input logic ack, input logic done);
        tick();
        check(name, col, seg, ack, done);
    endtask

    initial begin
        RSTn = 1'b0;  bus.Enable = 1'b1;  bus.Load_Req = 1'b0;
        bus.Load_Data = 8'h00;  bus.Load_Dp = 2'b00;

        // reset, release into SHOW, then load 35/01 from IDLE and scan one frame
        add(2, 0,1,0,8'h00,2'b00, 2'b11,8'hFF,0,0);
        add(1, 1,1,0,8'h00,2'b00, 2'b10,8'hC0,0,0);
        add(1, 1,0,0,8'h00,2'b00, 2'b11,8'hFF,0,0);
        add(1, 1,0,1,8'h35,2'b01, 2'b11,8'hFF,1,0);
        add(1, 1,0,0,8'h35,2'b01, 2'b11,8'hFF,0,0);
        add(4, 1,1,0,8'h35,2'b01, 2'b10,8'h12,0,0);
        add(2, 1,1,0,8'h35,2'b01, 2'b11,8'hFF,0,0);
        add(4, 1,1,0,8'h35,2'b01, 2'b01,8'hB0,0,0);
        add(2, 1,1,0,8'h35,2'b01, 2'b11,8'hFF,0,0);
        add(1, 1,1,0,8'h35,2'b01, 2'b10,8'h12,0,1);
        // mid-frame request for A0: held off until the frame boundary
        add(3, 1,1,1,8'hA0,2'b00, 2'b10,8'h12,0,0);
        add(2, 1,1,1,8'hA0,2'b00, 2'b11,8'hFF,0,0);
        add(4, 1,1,1,8'hA0,2'b00, 2'b01,8'hB0,0,0);
        add(2, 1,1,1,8'hA0,2'b00, 2'b11,8'hFF,0,0);
        add(1, 1,1,1,8'hA0,2'b00, 2'b10,8'hC0,1,1);
        add(3, 1,1,0,8'hA0,2'b00, 2'b10,8'hC0,0,0);
        add(2, 1,1,0,8'hA0,2'b00, 2'b11,8'hFF,0,0);
        add(1, 1,1,0,8'hA0,2'b00, 2'b01,8'h88,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            RSTn          = vecs[i].rstn;
            bus.Enable    = vecs[i].en;
            bus.Load_Req  = vecs[i].req;
            bus.Load_Data = vecs[i].data;
            bus.Load_Dp   = vecs[i].dp;
            step($sformatf("vec%0d", i), vecs[i].col, vecs[i].seg, vecs[i].ack, vecs[i].done);
        end

        // disable mid-SHOW, then re-enable restarts at digit0 for a full slot
        bus.Enable = 1'b0;
        step("dis_off", 2'b11, 8'hFF, 0, 0);
        bus.Enable = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("reen_d0_%0d", i), 2'b10, 8'hC0, 0, 0);
        for (int i = 0; i < 2; i++) step($sformatf("reen_bl_%0d", i), 2'b11, 8'hFF, 0, 0);
        for (int i = 0; i < 4; i++) step($sformatf("reen_d1_%0d", i), 2'b01, 8'h88, 0, 0);
        step("reen_bl2_0", 2'b11, 8'hFF, 0, 0);

        // pending request, then reset on the edge that would end the frame
        bus.Load_Req = 1'b1;  bus.Load_Data = 8'h5A;  bus.Load_Dp = 2'b11;
        step("pend_bl2_1", 2'b11, 8'hFF, 0, 0);
        RSTn = 1'b0;
        step("rst_midblank", 2'b11, 8'hFF, 0, 0);
        RSTn = 1'b1;  bus.Load_Req = 1'b0;
        for (int i = 0; i < 4; i++) step($sformatf("post_rst_d0_%0d", i), 2'b10, 8'hC0, 0, 0);
        for (int i = 0; i < 2; i++) step($sformatf("post_rst_bl_%0d", i), 2'b11, 8'hFF, 0, 0);
        step("post_rst_d1_shadow0", 2'b01, 8'hC0, 0, 0);

        // request held one extra cycle in IDLE gives a single ack
        bus.Enable = 1'b0;
        step("idle_off", 2'b11, 8'hFF, 0, 0);
        bus.Load_Req = 1'b1;  bus.Load_Data = 8'h7E;  bus.Load_Dp = 2'b10;
        step("hold_ack", 2'b11, 8'hFF, 1, 0);
        step("hold_no_ack2", 2'b11, 8'hFF, 0, 0);
        bus.Load_Req = 1'b0;
        step("hold_released", 2'b11, 8'hFF, 0, 0);
        bus.Enable = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("e_d0_%0d", i), 2'b10, 8'h86, 0, 0);
        for (int i = 0; i < 2; i++) step($sformatf("e_bl_%0d", i), 2'b11, 8'hFF, 0, 0);
        for (int i = 0; i < 4; i++) step($sformatf("e_d1_%0d", i), 2'b01, 8'h78, 0, 0);
        for (int i = 0; i < 2; i++) step($sformatf("e_bl2_%0d", i), 2'b11, 8'hFF, 0, 0);
        step("e_frame_done", 2'b10, 8'h86, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
